// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and helpers for the hazard scoreboard: the encoded
//            stall reason, the default register-index width and the width
//            helper for the per-register pending counters.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  localparam int DEFAULT_REG_AW = 5;

  typedef enum logic [1:0] {
    REASON_NONE     = 2'd0,
    REASON_MEM      = 2'd1,
    REASON_RAW      = 2'd2,
    REASON_WAW_FULL = 2'd3
  } stall_reason_e;

  // Bits needed to hold a pending count from 0 up to max_pend inclusive.
  function automatic int pend_w(input int max_pend);
    return (max_pend < 1) ? 1 : $clog2(max_pend + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_if
// Purpose  : Bundles the issue, completion, kill, wait, stall and perf signals
//            exchanged between the core pipeline (master) and the hazard
//            scoreboard (slave).
// Ports    : none (signal bundle); modports master / slave.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int CMPL_PORTS = 2,
  parameter int CNT_W      = 32
);
  // Issue side
  logic                         issue_valid_i;
  logic                         issue_long_i;
  logic [REG_AW-1:0]            issue_rd_i;
  logic [NUM_SRC-1:0]           issue_src_valid_i;
  logic [NUM_SRC*REG_AW-1:0]    issue_src_i;
  // Completion / flush side
  logic [CMPL_PORTS-1:0]        cmpl_valid_i;
  logic [CMPL_PORTS*REG_AW-1:0] cmpl_rd_i;
  logic                         kill_valid_i;
  logic [REG_AW-1:0]            kill_rd_i;
  // Memory waits and perf control
  logic                         im_wait_i;
  logic                         dm_wait_i;
  logic                         perf_clr_i;
  // Results
  logic                         stall_o;
  logic [1:0]                   stall_reason_o;
  logic [(2**REG_AW)-1:0]       busy_o;
  logic                         err_o;
  logic [CNT_W-1:0]             perf_raw_o;
  logic [CNT_W-1:0]             perf_mem_o;

  modport master (
    output issue_valid_i, issue_long_i, issue_rd_i, issue_src_valid_i,
           issue_src_i, cmpl_valid_i, cmpl_rd_i, kill_valid_i, kill_rd_i,
           im_wait_i, dm_wait_i, perf_clr_i,
    input  stall_o, stall_reason_o, busy_o, err_o, perf_raw_o, perf_mem_o
  );

  modport slave (
    input  issue_valid_i, issue_long_i, issue_rd_i, issue_src_valid_i,
           issue_src_i, cmpl_valid_i, cmpl_rd_i, kill_valid_i, kill_rd_i,
           im_wait_i, dm_wait_i, perf_clr_i,
    output stall_o, stall_reason_o, busy_o, err_o, perf_raw_o, perf_mem_o
  );

endinterface
`default_nettype wire

// File: rtl/hazard_sb_entry.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sb_entry
// Purpose  : One scoreboard entry: saturating up/down count of in-flight long
//            writes to a single register, sticky underflow flag, busy bit.
// Ports    : ACLK, ARESETn  - clock, async active-low reset
//            accept          - an accepted long op targets this register
//            dec             - completions + kills for this register
//            pend            - current pending count (registered)
//            busy            - pend != 0
//            underflow       - sticky: more decrements than pending writes
// Revision : 1.0 - initial release
// ============================================================================
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int MAX_PEND = 3,
  parameter int DEC_W    = 2,
  parameter int PEND_W   = pend_w(MAX_PEND)
) (
  input  wire logic              ACLK,
  input  wire logic              ARESETn,
  input  wire logic              accept,
  input  wire logic [DEC_W-1:0]  dec,
  output logic      [PEND_W-1:0] pend,
  output logic                   busy,
  output logic                   underflow
);

  // Arithmetic is done one bit wider than either operand so that the
  // underflow compare and the upper clamp never wrap.
  localparam int SW = ((PEND_W > DEC_W) ? PEND_W : DEC_W) + 1;

  logic [SW-1:0]     sum;
  logic [SW-1:0]     dec_ext;
  logic [SW-1:0]     diff;
  logic              under;
  logic [PEND_W-1:0] pend_nxt;

  always_comb begin
    sum     = SW'(pend) + SW'(accept);
    dec_ext = SW'(dec);
    diff    = sum - dec_ext;
    under   = (dec_ext > sum);
    if (under) begin
      pend_nxt = '0;
    end else if (diff > SW'(MAX_PEND)) begin
      // Unreachable while the WAW_FULL stall gates accept; kept as a clamp.
      pend_nxt = PEND_W'(MAX_PEND);
    end else begin
      pend_nxt = diff[PEND_W-1:0];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      pend      <= '0;
      underflow <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (under) begin
        underflow <= 1'b1;
      end
    end
  end

  assign busy = |pend;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Per-register pending-write scoreboard between ID and issue.
//            Merges RAW, WAW-overflow and AXI memory-wait stalls into one
//            stall with an encoded reason and keeps saturating stall-cycle
//            performance counters.
// Ports    : ACLK     - clock
//            ARESETn  - asynchronous active-low reset
//            sb       - hazard_scoreboard_if.slave: issue, completion, kill,
//                       wait and perf-clear inputs; stall, reason, busy,
//                       err and perf counter outputs
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = DEFAULT_REG_AW,
  parameter int NUM_SRC    = 2,
  parameter int CMPL_PORTS = 2,
  parameter int MAX_PEND   = 3,
  parameter int CNT_W      = 32
) (
  input  wire logic          ACLK,
  input  wire logic          ARESETn,
  hazard_scoreboard_if.slave sb
);

  localparam int NREG = 2 ** REG_AW;
  localparam int PW   = pend_w(MAX_PEND);
  // dec[r] spans 0 .. CMPL_PORTS+1 (all ports plus a kill).
  localparam int DW   = $clog2(CMPL_PORTS + 2);
  localparam int CW   = ((PW > DW) ? PW : DW) + 1;

  logic [NREG-1:0][PW-1:0] pend;
  logic [NREG-1:0][DW-1:0] dec;
  logic [NREG-1:0]         busy;
  logic [NREG-1:0]         uflow;
  logic [NUM_SRC-1:0]      raw_src;

  logic          accept;
  logic          raw_hz;
  logic          waw_hz;
  logic          mem_hz;
  logic          stall;
  stall_reason_e reason;

  logic [CNT_W-1:0] raw_cnt;
  logic [CNT_W-1:0] mem_cnt;

  // Register 0 is hard-wired: never pending, never decremented.
  assign pend[0]  = '0;
  assign dec[0]   = '0;
  assign busy[0]  = 1'b0;
  assign uflow[0] = 1'b0;

  // --------------------------------------------------------------------------
  // Per-register entries
  // --------------------------------------------------------------------------
  for (genvar r = 1; r < NREG; r++) begin : g_entry
    logic [DW-1:0] dec_r;
    logic          acc_r;

    always_comb begin
      dec_r = '0;
      for (int p = 0; p < CMPL_PORTS; p++) begin
        if (sb.cmpl_valid_i[p] &&
            (sb.cmpl_rd_i[p*REG_AW +: REG_AW] == REG_AW'(r))) begin
          dec_r = dec_r + 1'b1;
        end
      end
      if (sb.kill_valid_i && (sb.kill_rd_i == REG_AW'(r))) begin
        dec_r = dec_r + 1'b1;
      end
    end

    assign acc_r  = accept && (sb.issue_rd_i == REG_AW'(r));
    assign dec[r] = dec_r;

    hazard_sb_entry #(
      .MAX_PEND (MAX_PEND),
      .DEC_W    (DW),
      .PEND_W   (PW)
    ) u_entry (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .accept    (acc_r),
      .dec       (dec_r),
      .pend      (pend[r]),
      .busy      (busy[r]),
      .underflow (uflow[r])
    );
  end

  // --------------------------------------------------------------------------
  // Source-match reduction. Only completions count as hits: a same-cycle
  // writeback is forwarded, while a kill means the value never arrives.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [REG_AW-1:0] src;
    logic [DW-1:0]     hits;
    logic              raw_k;

    always_comb begin
      src  = sb.issue_src_i[k*REG_AW +: REG_AW];
      hits = '0;
      for (int p = 0; p < CMPL_PORTS; p++) begin
        if (sb.cmpl_valid_i[p] &&
            (sb.cmpl_rd_i[p*REG_AW +: REG_AW] == src)) begin
          hits = hits + 1'b1;
        end
      end
      raw_k = sb.issue_valid_i && sb.issue_src_valid_i[k] &&
              (src != '0) && (CW'(pend[src]) > CW'(hits));
    end

    assign raw_src[k] = raw_k;
  end

  // --------------------------------------------------------------------------
  // Stall conditions and priority encoding
  // --------------------------------------------------------------------------
  always_comb begin
    raw_hz = |raw_src;
    // pend - dec >= MAX_PEND rewritten as pend >= MAX_PEND + dec to stay
    // unsigned.
    waw_hz = sb.issue_valid_i && sb.issue_long_i && (sb.issue_rd_i != '0) &&
             (CW'(pend[sb.issue_rd_i]) >=
              (CW'(MAX_PEND) + CW'(dec[sb.issue_rd_i])));
    mem_hz = sb.im_wait_i || sb.dm_wait_i;
    stall  = raw_hz || waw_hz || mem_hz;

    if (mem_hz) begin
      reason = REASON_MEM;
    end else if (raw_hz) begin
      reason = REASON_RAW;
    end else if (waw_hz) begin
      reason = REASON_WAW_FULL;
    end else begin
      reason = REASON_NONE;
    end

    // stall feeds back into state only through this accept term.
    accept = sb.issue_valid_i && !stall && sb.issue_long_i &&
             (sb.issue_rd_i != '0);
  end

  // --------------------------------------------------------------------------
  // Saturating stall-cycle counters; clear wins over increment.
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      raw_cnt <= '0;
      mem_cnt <= '0;
    end else begin
      if (sb.perf_clr_i) begin
        raw_cnt <= '0;
      end else if ((reason == REASON_RAW) && (raw_cnt != '1)) begin
        raw_cnt <= raw_cnt + 1'b1;
      end

      if (sb.perf_clr_i) begin
        mem_cnt <= '0;
      end else if ((reason == REASON_MEM) && (mem_cnt != '1)) begin
        mem_cnt <= mem_cnt + 1'b1;
      end
    end
  end

  assign sb.stall_o        = stall;
  assign sb.stall_reason_o = reason;
  assign sb.busy_o         = busy;
  assign sb.err_o          = |uflow;
  assign sb.perf_raw_o     = raw_cnt;
  assign sb.perf_mem_o     = mem_cnt;

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline hazard unit. It tracks in-flight long-latency register writes (loads, mul, div) in a per-register pending-count scoreboard instead of matching EX/MEM/WB destination fields, so a variable-latency AXI load or an iterative divider stalls ID exactly as long as needed. It sits between ID and the issue point of the CPU core. It merges RAW, write-after-write (WAW) overflow and AXI memory-wait stalls into one stall with an encoded reason, and keeps saturating stall-cycle performance counters.

## Interface
Parameters:
- REG_AW, 5, register index width; register 0 is never tracked.
- NUM_SRC, 2, source operands checked per issuing instruction.
- CMPL_PORTS, 2, independent writeback/completion ports.
- MAX_PEND, 3, maximum in-flight long writes to one register.
- CNT_W, 32, performance counter width.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  instruction in ID wants to issue; it is accepted only when stall_o=0.
- issue_long_i  in  1  the issuing instruction is a long-latency register writer.
- issue_rd_i  in  REG_AW  destination register of the issuing instruction.
- issue_src_valid_i  in  NUM_SRC  per-source "operand is a register".
- issue_src_i  in  NUM_SRC*REG_AW  source indices; source k occupies bits [k*REG_AW +: REG_AW].
- cmpl_valid_i  in  CMPL_PORTS  a long op writes back this cycle.
- cmpl_rd_i  in  CMPL_PORTS*REG_AW  completing destinations.
- kill_valid_i  in  1  an accepted long op was flushed before completion.
- kill_rd_i  in  REG_AW  destination of the flushed op.
- im_wait_i  in  1  instruction AXI fetch is not done.
- dm_wait_i  in  1  data AXI access is not done.
- perf_clr_i  in  1  synchronous clear of the performance counters.
- stall_o  out  1  freeze IF/ID.
- stall_reason_o  out  2  NONE=0, MEM=1, RAW=2, WAW_FULL=3.
- busy_o  out  2**REG_AW  bit r is 1 when pend[r]≠0.
- err_o  out  1  sticky: a completion or kill was seen for a register with pend=0.
- perf_raw_o  out  CNT_W  count of RAW-stall cycles.
- perf_mem_o  out  CNT_W  count of MEM-stall cycles.

## Operation
- Per-register counter pend[r], width $clog2(MAX_PEND+1). pend[0] is held at 0. Issue, completion and kill requests to r=0 are ignored.
- dec[r] is the number of cmpl ports with cmpl_rd=r, plus kill_valid_i when kill_rd_i=r. dec[r] ranges from 0 to CMPL_PORTS+1.
- A RAW hazard exists on source k when issue_valid_i, the src_valid bit and src≠0 are all true and pend[src] − cmpl_hits(src) > 0.
  - cmpl_hits counts completions only. A same-cycle writeback is forwarded and does not stall.
  - Kills do not resolve a RAW hazard.
- WAW_FULL exists when issue_valid_i, issue_long_i and rd≠0 are true and pend[rd] − dec[rd] ≥ MAX_PEND.
- MEM stall is im_wait_i | dm_wait_i.
- stall_o is the OR of the three conditions. stall_reason_o takes priority MEM > RAW > WAW_FULL, and is NONE when stall_o=0.
- Accepted issue is issue_valid_i & ~stall_o & issue_long_i & rd≠0. On the next edge, pend[r] ← pend[r] + accept(r) − dec[r].
  - A same-cycle issue and completion on the same register leaves pend unchanged.
- Underflow: if dec[r] > pend[r] + accept(r), pend[r] saturates at 0 and err_o is set. err_o clears only on reset.
- Perf counters:
  - perf_raw_o increments in cycles where stall_reason_o=RAW.
  - perf_mem_o increments in cycles where stall_reason_o=MEM.
  - Both saturate at all-ones.
  - perf_clr_i has priority over increment; the counter reads 0 on the next cycle.

## Timing
- Asynchronous reset: all pend=0, busy_o=0, err_o=0, perf counters 0. stall_o and stall_reason_o are combinational, so they are 0 during reset while im_wait_i and dm_wait_i are low.
- stall_o and stall_reason_o are combinational from inputs and pend, with zero latency.
- busy_o, err_o and the perf counters are registered and reflect updates one cycle after the triggering edge.
- Reset asserted mid-operation drops all outstanding state. The core is expected to flush the pipeline together with the reset.
- There is no combinational path from stall_o back into the pend next-state, other than through the accept term.

## Structure
- hazard_pkg holds the stall_reason_e enum, the default REG_AW, and a pend_t width helper.
- Sub-module hazard_sb_entry is one per register. It holds the saturating up/down counter, the underflow flag and the busy bit, and is instantiated with a generate loop over registers 1..2**REG_AW−1.
- The top level contains the source-match reduction, the stall/priority logic and the perf counters.

## Test plan
- Issue a long op to x5. Then issue with src x5 and no completion for 4 cycles → stall_o=1 with reason RAW; perf_raw_o=4.
- Put cmpl x5 and an issue reading x5 in the same cycle → stall_o=0, and pend[5] reaches 0 (busy_o[5]=0) on the next cycle.
- Issue three long ops to x7 with MAX_PEND=3, then a fourth → reason WAW_FULL. Complete one x7 in the same cycle as the fourth issue → no stall, and pend[7] stays 3.
- Hold dm_wait_i=1 together with a RAW hazard → reason MEM; perf_mem_o increments and perf_raw_o holds.
- Send a completion to x9 while pend[9]=0 → err_o=1 next cycle and pend[9] stays 0. Issue with rd=x0 → busy_o unchanged.
- Assert ARESETn=0 with pend[3]=2 and perf counters nonzero → everything reads 0 immediately, and stays 0 until new issues arrive after reset is released.
